// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults and types for the FIR MAC controller.
//   TAPS_DEF / DW_DEF / MAC_LAT_DEF : default tap count, sample width, MAC latency
//   AW                              : address width for the default tap count
//   fir_state_e                     : controller state encoding
//   cnt_width()                     : width of the shared tap/drain counter
package fir_pkg;

  localparam int TAPS_DEF    = 8;
  localparam int DW_DEF      = 12;
  localparam int MAC_LAT_DEF = 2;
  localparam int AW          = $clog2(TAPS_DEF);

  typedef enum logic [1:0] {
    ST_CLR   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MAC   = 2'd2,
    ST_DRAIN = 2'd3
  } fir_state_e;

  // One counter serves both the tap walk and the drain wait, so it must
  // hold values up to max(TAPS, MAC_LAT) - 1.
  function automatic int cnt_width(input int taps, input int lat);
    int m;
    m = (taps > lat) ? taps : lat;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fir_ring_ptr.sv
// fir_ring_ptr: modulo-TAPS pointer arithmetic for the sample ring buffer.
// TAPS is a power of two, so wrapping is the natural overflow of W bits.
//   wptr     in  W  write pointer to advance
//   base     in  W  pointer to subtract from (newest sample)
//   off      in  W  offset subtracted from base (tap index)
//   wptr_nxt out W  wptr + 1 mod TAPS
//   diff     out W  base - off mod TAPS
module fir_ring_ptr
  import fir_pkg::*;
#(
  parameter int W = AW
) (
  input  logic [W-1:0] wptr,
  input  logic [W-1:0] base,
  input  logic [W-1:0] off,
  output logic [W-1:0] wptr_nxt,
  output logic [W-1:0] diff
);

  assign wptr_nxt = wptr + W'(1);
  assign diff     = base - off;

endmodule

// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: sequencer for a single-MAC FIR filter.
// Clears the sample ring, accepts one sample at a time, walks TAPS taps
// through an external MAC, waits MAC_LAT cycles and pulses valid.
//   clk, rstn       clock, asynchronous active-low reset
//   clr             synchronous re-zero of the sample buffer (aborts work)
//   en, xin         sample valid and data; accepted when en && in_rdy
//   in_rdy          controller is idle and can take a sample
//   smp_we/waddr/wdata  sample-buffer write port
//   smp_raddr       sample-buffer read address (newest - k)
//   coef_addr       coefficient ROM address (k)
//   mac_clr/en/last MAC control: load, accumulate, final tap
//   valid           one-cycle pulse: accumulator holds a finished output
module fir_mac_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS    = TAPS_DEF,
  parameter int DW      = DW_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     en,
  input  logic [DW-1:0]            xin,
  output logic                     in_rdy,
  output logic                     smp_we,
  output logic [$clog2(TAPS)-1:0]  smp_waddr,
  output logic [DW-1:0]            smp_wdata,
  output logic [$clog2(TAPS)-1:0]  smp_raddr,
  output logic [$clog2(TAPS)-1:0]  coef_addr,
  output logic                     mac_clr,
  output logic                     mac_en,
  output logic                     mac_last,
  output logic                     valid
);

  localparam int PW = $clog2(TAPS);
  localparam int KW = cnt_width(TAPS, MAC_LAT);
  localparam logic [KW-1:0] K_ZERO     = {KW{1'b0}};
  localparam logic [KW-1:0] K_TAP_LAST = KW'(TAPS - 1);
  localparam logic [KW-1:0] K_LAT_LAST = KW'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
  localparam logic [PW-1:0] P_ZERO     = {PW{1'b0}};
  localparam logic [DW-1:0] D_ZERO     = {DW{1'b0}};

  fir_state_e    state_r;
  logic [KW-1:0] k_r;
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] newest_r;
  logic          in_rdy_r;
  logic          we_r;
  logic [PW-1:0] waddr_r;
  logic [PW-1:0] raddr_r;
  logic [PW-1:0] coef_r;
  logic          mclr_r;
  logic          men_r;
  logic          mlast_r;
  logic          valid_r;

  logic [KW-1:0] k_inc_s;
  logic [PW-1:0] k_off_s;
  logic [PW-1:0] wptr_nxt_s;
  logic [PW-1:0] raddr_nxt_s;
  logic          accept_s;

  assign k_inc_s  = k_r + KW'(1);
  assign k_off_s  = k_inc_s[PW-1:0];
  // clr has priority: a sample offered alongside clr is refused outright.
  assign accept_s = in_rdy_r & en & ~clr;

  // Pointer arithmetic: next write slot and read address for the next tap.
  fir_ring_ptr #(.W(PW)) u_ptr (
    .wptr     (wptr_r),
    .base     (newest_r),
    .off      (k_off_s),
    .wptr_nxt (wptr_nxt_s),
    .diff     (raddr_nxt_s)
  );

  // Controller FSM; every output register holds the value for the cycle
  // that follows the edge, so outputs come straight from flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= ST_CLR;
      k_r      <= K_ZERO;
      wptr_r   <= P_ZERO;
      newest_r <= P_ZERO;
      in_rdy_r <= 1'b0;
      we_r     <= 1'b0;
      waddr_r  <= P_ZERO;
      raddr_r  <= P_ZERO;
      coef_r   <= P_ZERO;
      mclr_r   <= 1'b0;
      men_r    <= 1'b0;
      mlast_r  <= 1'b0;
      valid_r  <= 1'b0;
    end else if (clr) begin
      // Abort anything in flight and restart the clear walk at address 0.
      state_r  <= ST_CLR;
      k_r      <= K_ZERO;
      in_rdy_r <= 1'b0;
      we_r     <= 1'b1;
      waddr_r  <= P_ZERO;
      raddr_r  <= P_ZERO;
      coef_r   <= P_ZERO;
      mclr_r   <= 1'b0;
      men_r    <= 1'b0;
      mlast_r  <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_CLR: begin
          if (!we_r) begin
            // First edge after reset release: start writing address 0.
            we_r    <= 1'b1;
            waddr_r <= P_ZERO;
            k_r     <= K_ZERO;
          end else if (k_r == K_TAP_LAST) begin
            state_r  <= ST_IDLE;
            k_r      <= K_ZERO;
            we_r     <= 1'b0;
            waddr_r  <= P_ZERO;
            wptr_r   <= P_ZERO;
            in_rdy_r <= 1'b1;
          end else begin
            k_r     <= k_inc_s;
            waddr_r <= k_off_s;
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            newest_r <= wptr_r;
            wptr_r   <= wptr_nxt_s;
            state_r  <= ST_MAC;
            k_r      <= K_ZERO;
            in_rdy_r <= 1'b0;
            men_r    <= 1'b1;
            mclr_r   <= 1'b1;
            mlast_r  <= (K_ZERO == K_TAP_LAST);
            coef_r   <= P_ZERO;
            raddr_r  <= wptr_r;
          end else begin
            in_rdy_r <= 1'b1;
          end
        end
        ST_MAC: begin
          if (k_r == K_TAP_LAST) begin
            k_r     <= K_ZERO;
            men_r   <= 1'b0;
            mclr_r  <= 1'b0;
            mlast_r <= 1'b0;
            coef_r  <= P_ZERO;
            raddr_r <= P_ZERO;
            if (MAC_LAT == 0) begin
              state_r  <= ST_IDLE;
              in_rdy_r <= 1'b1;
              valid_r  <= 1'b1;
            end else begin
              state_r <= ST_DRAIN;
            end
          end else begin
            k_r     <= k_inc_s;
            coef_r  <= k_off_s;
            raddr_r <= raddr_nxt_s;
            mclr_r  <= 1'b0;
            mlast_r <= (k_inc_s == K_TAP_LAST);
          end
        end
        ST_DRAIN: begin
          if (k_r == K_LAT_LAST) begin
            state_r  <= ST_IDLE;
            k_r      <= K_ZERO;
            in_rdy_r <= 1'b1;
            valid_r  <= 1'b1;
          end else begin
            k_r <= k_inc_s;
          end
        end
        default: begin
          state_r  <= ST_CLR;
          k_r      <= K_ZERO;
          in_rdy_r <= 1'b0;
          we_r     <= 1'b1;
          waddr_r  <= P_ZERO;
          raddr_r  <= P_ZERO;
          coef_r   <= P_ZERO;
          mclr_r   <= 1'b0;
          men_r    <= 1'b0;
          mlast_r  <= 1'b0;
        end
      endcase
    end
  end

  // The accept-cycle write is combinational so the sample lands in the
  // same cycle it is offered; the clear walk comes from registers.
  assign smp_we    = we_r | accept_s;
  assign smp_waddr = accept_s ? wptr_r : waddr_r;
  assign smp_wdata = accept_s ? xin : D_ZERO;
  assign in_rdy    = in_rdy_r;
  assign smp_raddr = raddr_r;
  assign coef_addr = coef_r;
  assign mac_clr   = mclr_r;
  assign mac_en    = men_r;
  assign mac_last  = mlast_r;
  assign valid     = valid_r;

endmodule

// File: doc/fir_mac_ctrl.md
FIR_MAC_CTRL -- requirements
Module: fir_mac_ctrl

Interface
REQ-001 Parameter TAPS, default 8, number of filter taps and sample-buffer depth (power of 2).
REQ-002 Parameter DW, default 12, input sample width.
REQ-003 Parameter MAC_LAT, default 2, pipeline latency of the external MAC from last mac_en to settled accumulator.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 clr  input  1  synchronous request to re-zero the sample buffer.
REQ-007 en  input  1  input sample valid.
REQ-008 xin  input  DW  input sample.
REQ-009 in_rdy  output  1  controller can accept a sample this cycle.
REQ-010 smp_we  output  1  sample-buffer write strobe.
REQ-011 smp_waddr  output  log2(TAPS)  sample-buffer write address.
REQ-012 smp_wdata  output  DW  sample-buffer write data.
REQ-013 smp_raddr  output  log2(TAPS)  sample-buffer read address.
REQ-014 coef_addr  output  log2(TAPS)  coefficient ROM address.
REQ-015 mac_clr  output  1  load the accumulator with the product instead of adding it.
REQ-016 mac_en  output  1  MAC accumulate enable.
REQ-017 mac_last  output  1  marks the final tap of a sample.
REQ-018 valid  output  1  one-cycle pulse: accumulator holds a finished output.

Function
REQ-019 States SHALL be CLR, IDLE, MAC, DRAIN.
REQ-020 CLR: smp_we=1 and smp_wdata=0 for TAPS consecutive cycles, with smp_waddr stepping 0..TAPS-1; in_rdy=0; then go to IDLE with wptr=0.
REQ-021 IDLE: in_rdy=1; a sample is accepted when en && in_rdy.
REQ-022 On accept (cycle 0): smp_we=1, smp_waddr=wptr and smp_wdata=xin, all combinational in the same cycle; newest<=wptr; wptr<=wptr+1 mod TAPS; next state MAC.
REQ-023 MAC: tap counter k runs 0..TAPS-1 over cycles 1..TAPS; mac_en=1; coef_addr=k; smp_raddr=(newest-k) mod TAPS; mac_clr=1 only at k=0; mac_last=1 only at k=TAPS-1; in_rdy=0.
REQ-024 After k=TAPS-1: DRAIN for MAC_LAT cycles, mac_en=0, in_rdy=0.
REQ-025 valid is registered and SHALL pulse high for exactly one cycle, at cycle 1+TAPS+MAC_LAT after accept, coincident with the return to IDLE (in_rdy=1 in that cycle).
REQ-026 Throughput: one sample per TAPS+MAC_LAT+1 cycles; an en held through the busy cycles is accepted on the first in_rdy cycle, and no sample is dropped or duplicated.
REQ-027 clr sampled in any state SHALL abort the current work at the next edge: state<=CLR, k<=0, no valid pulse for the aborted sample. clr wins over a simultaneous en.
REQ-028 clr asserted during CLR SHALL restart the CLR sequence from address 0.
REQ-029 wptr, newest and raddr arithmetic SHALL be modulo TAPS; wrap from TAPS-1 to 0 is seamless.
REQ-030 In every cycle, outputs not driven by the current state SHALL be 0, including the address outputs.

Reset
REQ-031 While rstn=0: state=CLR at k=0, wptr=0, newest=0, and all outputs 0 (in_rdy=0, valid=0, smp_we=0, mac_*=0).
REQ-032 The first cycle after rstn deasserts SHALL begin the CLR sequence; reset asserted mid-MAC discards the sample with no valid pulse.

Structure
REQ-033 Package fir_pkg SHALL hold the TAPS/DW/MAC_LAT defaults, the AW=$clog2(TAPS) constant and the state enum type.
REQ-034 One sub-module, fir_ring_ptr, SHALL implement the modulo-TAPS pointer (increment and subtract-offset).
REQ-035 The expected RTL size is 120-400 lines, with no datapath arithmetic beyond the pointers and counters.

Verification
REQ-036 Reset release -> cycles 0..7 smp_we=1, waddr 0..7, wdata 0, then in_rdy=1 in cycle 8.
REQ-037 Single sample 0x123 with en at cycle t -> smp_wdata=0x123 at addr 0 in cycle t; mac_clr in t+1; mac_last in t+8; coef_addr 0..7; raddr 0,7,6,...,1; valid only at t+11.
REQ-038 en held high continuously, with 20 samples ramping 1..20 -> exactly 20 accepts at 11-cycle spacing, 20 valid pulses, waddr wrapping 7->0 after sample 8.
REQ-039 clr at cycle t+4 of a MAC with en also high -> no valid pulse; CLR sequence from addr 0; the sample offered during clr is not accepted.
REQ-040 rstn low at t+5 of a MAC -> all outputs 0 immediately (asynchronously); after release, the CLR sequence runs and the next sample is written at addr 0.
REQ-041 A bench scoreboard with TAPS=8 and an ideal MAC model fed cosine samples -> every output matches the reference convolution, with zero history for the first 7 outputs.
